// File: rtl/spi_pkg.sv
// Shared SPI types and constants used by the link transmitter and receiver.
package spi_pkg;

   localparam int unsigned SPI_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      RECV
   } spi_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer with an asynchronous reset to a chosen level.
module sync_ff #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_q <= {STAGES{RESET_VAL}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI link receiver: synchronizes the three link wires, shifts data MSB-first on
// data-clock rising edges and emits completed words or a partial-frame error strobe.
module spi_rx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = SPI_DEFAULT_WIDTH,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  data_in,
   input  logic                  data_clk_in,
   input  logic                  sel_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  error_out
);

   localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned PW = $clog2(SYNC_STAGES + 1);

   logic                  sync_data;
   logic                  sync_clk;
   logic                  sync_sel;
   logic                  prev_clk_q;
   logic                  sck_rise;
   logic                  sel_lo;

   spi_rx_state_t         state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         prime_q, prime_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (data_in),
      .q_o   (sync_data)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (data_clk_in),
      .q_o   (sync_clk)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (sel_in),
      .q_o   (sync_sel)
   );

   assign sck_rise = sync_clk & ~prev_clk_q;
   assign sel_lo   = ~sync_sel;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= WAIT_IDLE;
         prev_clk_q <= 1'b0;
         shift_q    <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         prime_q    <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_clk_q <= sync_clk;
         shift_q    <= shift_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         prime_q    <= prime_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      prime_d = (prime_q == PW'(SYNC_STAGES)) ? prime_q : prime_q + 1'b1;

      unique case (state_q)
         // The sel chain resets to idle, so its output is only trusted once the
         // chain has refilled from the pin; otherwise a frame in flight at reset
         // release would be picked up mid-word.
         WAIT_IDLE: begin
            if (sync_sel && (prime_q == PW'(SYNC_STAGES))) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (sel_lo) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = RECV;
            end
         end

         RECV: begin
            if (sck_rise) begin
               shift_d = {shift_q[DATA_WIDTH-2:0], sync_data};
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  cnt_d   = '0;
                  data_d  = shift_d;
                  valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // End-of-frame check sees the count after any same-cycle shift.
            if (sync_sel) begin
               state_d = IDLE;
               if (cnt_d != '0) begin
                  err_d = 1'b1;
               end
            end
         end

         default: state_d = WAIT_IDLE;
      endcase
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign error_out = err_q;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: a link transmitter model drives frames and a
// word-level reference model predicts completed words and partial-frame errors.
module tb_spi_rx;

   localparam int DW   = 8;
   localparam int SS   = 2;
   localparam int HALF = 50;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          din  = 1'b0;
   logic          dclk = 1'b0;
   logic          sel  = 1'b1;
   logic [DW-1:0] dout;
   logic          vld;
   logic          err;

   spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .data_in     (din),
      .data_clk_in (dclk),
      .sel_in      (sel),
      .data_out    (dout),
      .valid_out   (vld),
      .error_out   (err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] obs_q[$];
   int            err_cnt    = 0;
   int            both_cnt   = 0;
   int            glitch_cnt = 0;
   logic [DW-1:0] last_dout  = '0;

   logic [DW-1:0] exp_q[$];
   int            exp_err;

   always @(negedge clk) begin
      if (rst) begin
         last_dout = dout;
      end else begin
         if (vld) obs_q.push_back(dout);
         if (err) err_cnt++;
         if (vld && err) both_cnt++;
         if (!vld && dout !== last_dout) glitch_cnt++;
         last_dout = dout;
      end
   end

   // Reference: every full group of DW bits is a word, a leftover tail is an error.
   function automatic void model(input logic [63:0] v, input int n);
      for (int k = 0; k < n / DW; k++) exp_q.push_back(DW'(v >> (n - (k + 1) * DW)));
      if (n % DW != 0) exp_err++;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      din = b;
      wait_clk(HALF);
      dclk = 1'b1;
      wait_clk(HALF);
      dclk = 1'b0;
   endtask

   task automatic frame(input logic [63:0] v, input int n);
      sel = 1'b0;
      wait_clk(HALF);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
      wait_clk(HALF);
      sel = 1'b1;
      wait_clk(1);
      model(v, n);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      wait_clk(3);
      tests++;
      if (dout !== '0 || vld !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got data=%h valid=%b error=%b, need 00/0/0", dout, vld, err);
      end
      rst = 1'b0;
      wait_clk(10);
      tests++;
      if (vld !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: got valid=%b error=%b, need 0/0", vld, err);
      end
   endtask

   task automatic test_single;
      int b = obs_q.size();
      int e = err_cnt;
      exp_q.delete();
      exp_err = 0;
      frame(64'hA5, 8);
      wait_clk(10);
      tests++;
      if (obs_q.size() - b != exp_q.size()) begin
         fails++;
         $display("FAIL single_count: got %0d words, need %0d", obs_q.size() - b, exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[b + k] !== exp_q[k]) begin
               fails++;
               $display("FAIL single_word%0d: got %h, need %h", k, obs_q[b + k], exp_q[k]);
            end
         end
      end
      tests++;
      if (err_cnt - e != exp_err) begin
         fails++;
         $display("FAIL single_err: got %0d errors, need %0d", err_cnt - e, exp_err);
      end
   endtask

   task automatic test_back_to_back;
      int b = obs_q.size();
      int e = err_cnt;
      exp_q.delete();
      exp_err = 0;
      frame(64'h3C, 8);
      frame(64'hFF, 8);
      wait_clk(10);
      tests++;
      if (obs_q.size() - b != exp_q.size()) begin
         fails++;
         $display("FAIL b2b_count: got %0d words, need %0d", obs_q.size() - b, exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[b + k] !== exp_q[k]) begin
               fails++;
               $display("FAIL b2b_word%0d: got %h, need %h", k, obs_q[b + k], exp_q[k]);
            end
         end
      end
      tests++;
      if (err_cnt - e != exp_err) begin
         fails++;
         $display("FAIL b2b_err: got %0d errors, need %0d", err_cnt - e, exp_err);
      end
   endtask

   task automatic test_truncated;
      int b = obs_q.size();
      int e = err_cnt;
      exp_q.delete();
      exp_err = 0;
      frame(64'h3C, 8);
      frame(64'b10110, 5);
      wait_clk(10);
      tests++;
      if (obs_q.size() - b != exp_q.size()) begin
         fails++;
         $display("FAIL trunc_count: got %0d words, need %0d", obs_q.size() - b, exp_q.size());
      end
      tests++;
      if (err_cnt - e != exp_err) begin
         fails++;
         $display("FAIL trunc_err: got %0d errors, need %0d", err_cnt - e, exp_err);
      end
      tests++;
      if (dout !== exp_q[exp_q.size() - 1]) begin
         fails++;
         $display("FAIL trunc_hold: got data=%h, need %h", dout, exp_q[exp_q.size() - 1]);
      end
   endtask

   task automatic test_streaming;
      int b = obs_q.size();
      int e = err_cnt;
      exp_q.delete();
      exp_err = 0;
      frame(64'h1234, 16);
      wait_clk(10);
      tests++;
      if (obs_q.size() - b != exp_q.size()) begin
         fails++;
         $display("FAIL stream_count: got %0d words, need %0d", obs_q.size() - b, exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[b + k] !== exp_q[k]) begin
               fails++;
               $display("FAIL stream_word%0d: got %h, need %h", k, obs_q[b + k], exp_q[k]);
            end
         end
      end
      tests++;
      if (err_cnt - e != exp_err) begin
         fails++;
         $display("FAIL stream_err: got %0d errors, need %0d", err_cnt - e, exp_err);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] v = 8'h81;
      int b;
      int e;
      sel = 1'b0;
      wait_clk(HALF);
      for (int i = 7; i >= 5; i--) send_bit(v[i]);
      rst = 1'b1;
      wait_clk(2);
      tests++;
      if (dout !== '0) begin
         fails++;
         $display("FAIL midrst_data: got %h, need 00", dout);
      end
      rst = 1'b0;
      b = obs_q.size();
      e = err_cnt;
      for (int i = 4; i >= 0; i--) send_bit(v[i]);
      wait_clk(HALF);
      sel = 1'b1;
      wait_clk(10);
      tests++;
      if (obs_q.size() != b || err_cnt != e) begin
         fails++;
         $display("FAIL midrst_quiet: got %0d words %0d errors, need 0 and 0", obs_q.size() - b, err_cnt - e);
      end
      exp_q.delete();
      exp_err = 0;
      frame(64'h5A, 8);
      wait_clk(10);
      tests++;
      if (obs_q.size() - b != 1 || obs_q[obs_q.size() - 1] !== exp_q[0]) begin
         fails++;
         $display("FAIL midrst_next: got %0d words last=%h, need 1 word %h", obs_q.size() - b,
                  (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0, exp_q[0]);
      end
   endtask

   task automatic test_idle_noise;
      int b = obs_q.size();
      int e = err_cnt;
      logic [DW-1:0] held = dout;
      for (int i = 0; i < 20; i++) begin
         din = 1'($urandom);
         wait_clk(5);
         dclk = 1'b1;
         wait_clk(5);
         dclk = 1'b0;
      end
      wait_clk(10);
      tests++;
      if (obs_q.size() != b || err_cnt != e || dout !== held) begin
         fails++;
         $display("FAIL noise: got %0d words %0d errors data=%h, need 0/0/%h", obs_q.size() - b, err_cnt - e, dout, held);
      end
   endtask

   task automatic test_random;
      int b = obs_q.size();
      int e = err_cnt;
      exp_q.delete();
      exp_err = 0;
      for (int f = 0; f < 6; f++) begin
         int n = $urandom_range(1, 24);
         logic [63:0] v = {32'h0, $urandom} & ((64'h1 << n) - 1);
         frame(v, n);
         wait_clk($urandom_range(0, 4));
      end
      wait_clk(10);
      tests++;
      if (obs_q.size() - b != exp_q.size()) begin
         fails++;
         $display("FAIL rand_count: got %0d words, need %0d", obs_q.size() - b, exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[b + k] !== exp_q[k]) begin
               fails++;
               $display("FAIL rand_word%0d: got %h, need %h", k, obs_q[b + k], exp_q[k]);
            end
         end
      end
      tests++;
      if (err_cnt - e != exp_err) begin
         fails++;
         $display("FAIL rand_err: got %0d errors, need %0d", err_cnt - e, exp_err);
      end
   endtask

   task automatic test_invariants;
      tests++;
      if (both_cnt != 0) begin
         fails++;
         $display("FAIL valid_and_error: got %0d overlapping cycles, need 0", both_cnt);
      end
      tests++;
      if (glitch_cnt != 0) begin
         fails++;
         $display("FAIL data_without_valid: got %0d changes, need 0", glitch_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_truncated();
      test_streaming();
      test_reset_mid_frame();
      test_idle_noise();
      test_random();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
